// File: rtl/pet2001kbd_pkg.sv
// Shared constants and types for the PS/2 to PET 2001 keyboard matrix bridge:
// special scancode bytes, deframer state encoding, keymap entry layout and
// the named keymap entries used by the test keys.
package pet2001kbd_pkg;

    // Set-2 special bytes
    localparam logic [7:0] PS2_E0 = 8'hE0;  // extended prefix
    localparam logic [7:0] PS2_F0 = 8'hF0;  // break prefix
    localparam logic [7:0] PS2_E1 = 8'hE1;  // pause prefix, ignored
    localparam logic [7:0] PS2_AA = 8'hAA;  // self-test passed, ignored
    localparam logic [7:0] PS2_FA = 8'hFA;  // ack, ignored
    localparam logic [7:0] PS2_FE = 8'hFE;  // resend request, ignored
    localparam logic [7:0] PS2_00 = 8'h00;  // overrun
    localparam logic [7:0] PS2_FF = 8'hFF;  // overrun

    // Deframer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } defr_state_t;

    // Keymap entry: {valid, row[3:0], col[2:0]}
    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
    } kmap_entry_t;

    localparam kmap_entry_t KM_NONE = '{valid: 1'b0, row: 4'd0, col: 3'd0};

    // Keymap addresses {ext, code} for the named keys
    localparam logic [8:0] KEY_A       = 9'h01C;
    localparam logic [8:0] KEY_LSHIFT  = 9'h012;
    localparam logic [8:0] KEY_RETURN  = 9'h05A;
    localparam logic [8:0] KEY_CRSR_DN = 9'h172;

    localparam kmap_entry_t ENT_A       = '{valid: 1'b1, row: 4'd4, col: 3'd0};
    localparam kmap_entry_t ENT_LSHIFT  = '{valid: 1'b1, row: 4'd8, col: 3'd0};
    localparam kmap_entry_t ENT_RETURN  = '{valid: 1'b1, row: 4'd6, col: 3'd5};
    localparam kmap_entry_t ENT_CRSR_DN = '{valid: 1'b1, row: 4'd1, col: 3'd7};

    // Build a valid keymap entry from a row/column pair
    function automatic kmap_entry_t km_entry(input logic [3:0] row, input logic [2:0] col);
        km_entry = '{valid: 1'b1, row: row, col: col};
    endfunction

    // PS/2 uses odd parity over the eight data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        odd_parity_ok = ^{data, par};
    endfunction

endpackage

// File: rtl/pet2001ps2_keymap.sv
// Combinational scancode ROM: {ext, set-2 code} -> PET matrix position.
// Codes without a PET equivalent return an entry with valid cleared.
module pet2001ps2_keymap
    import pet2001kbd_pkg::*;
(
    input  logic [8:0] i_addr,
    output logic [7:0] o_entry
);

    kmap_entry_t w_entry;

    // Scancode lookup
    always_comb begin
        w_entry = KM_NONE;
        case (i_addr)
            KEY_A:       w_entry = ENT_A;
            KEY_LSHIFT:  w_entry = ENT_LSHIFT;
            KEY_RETURN:  w_entry = ENT_RETURN;
            KEY_CRSR_DN: w_entry = ENT_CRSR_DN;
            9'h174:      w_entry = km_entry(4'd0, 3'd7);  // cursor right
            9'h16C:      w_entry = km_entry(4'd0, 3'd6);  // home
            9'h066:      w_entry = km_entry(4'd1, 3'd6);  // backspace -> DEL
            9'h015:      w_entry = km_entry(4'd2, 3'd0);  // Q
            9'h01D:      w_entry = km_entry(4'd2, 3'd1);  // W
            9'h024:      w_entry = km_entry(4'd2, 3'd2);  // E
            9'h02D:      w_entry = km_entry(4'd2, 3'd3);  // R
            9'h02C:      w_entry = km_entry(4'd2, 3'd4);  // T
            9'h035:      w_entry = km_entry(4'd2, 3'd5);  // Y
            9'h03C:      w_entry = km_entry(4'd2, 3'd6);  // U
            9'h043:      w_entry = km_entry(4'd2, 3'd7);  // I
            9'h01B:      w_entry = km_entry(4'd4, 3'd1);  // S
            9'h023:      w_entry = km_entry(4'd4, 3'd2);  // D
            9'h02B:      w_entry = km_entry(4'd4, 3'd3);  // F
            9'h034:      w_entry = km_entry(4'd4, 3'd4);  // G
            9'h033:      w_entry = km_entry(4'd4, 3'd5);  // H
            9'h03B:      w_entry = km_entry(4'd4, 3'd6);  // J
            9'h042:      w_entry = km_entry(4'd4, 3'd7);  // K
            9'h01A:      w_entry = km_entry(4'd6, 3'd0);  // Z
            9'h022:      w_entry = km_entry(4'd6, 3'd1);  // X
            9'h021:      w_entry = km_entry(4'd6, 3'd2);  // C
            9'h02A:      w_entry = km_entry(4'd6, 3'd3);  // V
            9'h032:      w_entry = km_entry(4'd6, 3'd4);  // B
            9'h059:      w_entry = km_entry(4'd8, 3'd5);  // right shift
            9'h031:      w_entry = km_entry(4'd8, 3'd2);  // N
            9'h03A:      w_entry = km_entry(4'd8, 3'd3);  // M
            9'h029:      w_entry = km_entry(4'd9, 3'd2);  // space
            default:     w_entry = KM_NONE;
        endcase
    end

    assign o_entry = w_entry;

endmodule

// File: rtl/pet2001ps2_kbd.sv
// PS/2 keyboard to PET 2001 key matrix. Deframes the serial PS/2 stream,
// decodes set-2 make/break/extended prefixes into an 80-bit pressed-key
// bitmap and returns the active-low column bits of the row the PIA selects.
module pet2001ps2_kbd
    import pet2001kbd_pkg::*;
#(
    parameter int CLK_HZ     = 32000000,
    parameter int TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    output logic       frame_err,
    output logic       key_valid
);

    localparam int unsigned TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_data_sync;
    logic              r_clk_prev;
    logic              w_fall;
    logic              w_data;

    defr_state_t       r_state;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic              r_par_ok;
    logic [31:0]       r_to_cnt;
    logic [7:0]        r_byte;
    logic              r_byte_vld;
    logic              r_frame_err;

    logic              r_ext;
    logic              r_brk;
    logic              r_key_valid;
    logic [9:0][7:0]   r_bitmap;

    logic [7:0]        w_km_entry;
    kmap_entry_t       w_entry;

    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_data    = r_data_sync[1];
    assign frame_err = r_frame_err;
    assign key_valid = r_key_valid;
    assign w_entry   = w_km_entry;

    pet2001ps2_keymap u_keymap (
        .i_addr  ({r_ext, r_byte}),
        .o_entry (w_km_entry)
    );

    // Synchronize the asynchronous PS/2 lines and keep the previous clock level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    // Frame deframer: start, 8 data bits LSB first, odd parity, stop, with idle timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_par_ok    <= 1'b0;
            r_to_cnt    <= 32'd0;
            r_byte      <= 8'd0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_fall || (r_state == ST_IDLE)) begin
                r_to_cnt <= 32'd0;
            end else if (r_to_cnt < TIMEOUT_CYC) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_data) begin
                            r_state  <= ST_SHIFT;
                            r_bitcnt <= 3'd0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_par_ok <= odd_parity_ok(r_shift, w_data);
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (w_data && r_par_ok) begin
                            r_byte     <= r_shift;
                            r_byte_vld <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if ((r_state != ST_IDLE) && (r_to_cnt >= TIMEOUT_CYC)) begin
                // Keyboard stalled mid-frame: drop the partial byte without an error
                r_state <= ST_IDLE;
            end
        end
    end

    // Prefix decoder and pressed-key bitmap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_key_valid <= 1'b0;
            r_bitmap    <= '0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_byte_vld) begin
                case (r_byte)
                    PS2_E0: r_ext <= 1'b1;
                    PS2_F0: r_brk <= 1'b1;
                    PS2_E1, PS2_AA, PS2_FA, PS2_FE: begin
                        // Protocol chatter with no key meaning; flags are kept
                        r_ext <= r_ext;
                    end
                    PS2_00, PS2_FF: begin
                        r_ext    <= 1'b0;
                        r_brk    <= 1'b0;
                        r_bitmap <= '0;
                    end
                    default: begin
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                        r_key_valid <= 1'b1;
                        if (w_entry.valid && (w_entry.row <= 4'd9)) begin
                            r_bitmap[w_entry.row][w_entry.col] <= ~r_brk;
                        end
                    end
                endcase
            end
        end
    end

    // Row readout is combinational because the PIA samples it in the same cycle
    always_comb begin
        keyin = 8'hFF;
        if (reset) begin
            keyin = 8'hFF;
        end else if (keyrow <= 4'd9) begin
            keyin = ~r_bitmap[keyrow];
        end else begin
            keyin = 8'hFF;
        end
    end

endmodule

// File: tb/tb_pet2001ps2_kbd.sv
// Directed bench for pet2001ps2_kbd: drives PS/2 frames, a scoreboard queue
// matches key_valid/frame_err pulses, and the matrix is read per row.
module tb_pet2001ps2_kbd;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keyrow;
    logic [7:0] keyin;
    logic       frame_err;
    logic       key_valid;

    int checks   = 0;
    int failures = 0;
    int sb_q[$];

    localparam int HALF = 20;  // system clocks per PS/2 half period

    pet2001ps2_kbd #(.CLK_HZ(32000000), .TIMEOUT_US(200)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keyrow    (keyrow),
        .keyin     (keyin),
        .frame_err (frame_err),
        .key_valid (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame bits in send order: start, data LSB first, odd parity, stop
    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic badpar);
        mkframe = {1'b1, (~^b) ^ badpar, b, 1'b0};
    endfunction

    // Expected event: 0 none, 1 key_valid, 2 frame_err
    function automatic int classify(input logic [7:0] b, input logic badpar);
        if (badpar) classify = 2;
        else if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1 || b == 8'hAA ||
                 b == 8'hFA || b == 8'hFE || b == 8'h00 || b == 8'hFF) classify = 0;
        else classify = 1;
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic badpar);
        int c;
        c = classify(b, badpar);
        if (c != 0) sb_q.push_back(c);
        send_bits(mkframe(b, badpar), 11);
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_row(input string tag, input logic [3:0] row, input logic [7:0] exp);
        keyrow = row;
        #1;
        checks++;
        assert (keyin === exp) else begin
            failures++;
            $error("FAIL %s row=%0d got=%h exp=%h", tag, row, keyin, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        int ev;
        int exp;
        if (key_valid === 1'b1 || frame_err === 1'b1) begin
            ev = {30'd0, frame_err, key_valid};
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $error("FAIL sb_unexpected got=%0d exp=none", ev);
            end else begin
                exp = sb_q.pop_front();
                assert (ev === exp) else begin
                    failures++;
                    $error("FAIL sb_event got=%0d exp=%0d", ev, exp);
                end
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        int   lat;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        keyrow   = 4'd0;
        repeat (3) @(negedge clk);
        chk_row("reset_keyin", 4'd4, 8'hFF);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_row("post_reset_keyin", 4'd0, 8'hFF);
        chk_bit("post_reset_key_valid", key_valid, 1'b0);
        chk_bit("post_reset_frame_err", frame_err, 1'b0);

        // A make with latency measured from the stop-bit edge
        sb_q.push_back(1);
        send_bits(mkframe(8'h1C, 1'b0), 10);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        keyrow  = 4'd4;
        #1;
        chk_row("a_before_stop", 4'd4, 8'hFF);
        ps2_clk = 1'b0;
        found = 1'b0;
        lat   = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!found && keyin === 8'hFE) begin
                found = 1'b1;
                lat   = k;
            end
        end
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        chk_bit("a_seen", found, 1'b1);
        checks++;
        assert (lat === 3) else begin
            failures++;
            $error("FAIL a_latency got=%0d exp=3", lat);
        end
        chk_row("a_row4", 4'd4, 8'hFE);
        chk_row("a_row5", 4'd5, 8'hFF);

        // Shift held while A is released
        send_byte(8'h12, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk_row("shift_held", 4'd8, 8'hFE);
        chk_row("a_released", 4'd4, 8'hFF);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        chk_row("shift_released", 4'd8, 8'hFF);

        // Extended cursor down
        send_byte(8'hE0, 1'b0);
        send_byte(8'h72, 1'b0);
        chk_row("crsr_dn_make", 4'd1, 8'h7F);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h72, 1'b0);
        chk_row("crsr_dn_break", 4'd1, 8'hFF);
        send_byte(8'h72, 1'b0);
        chk_row("plain_72", 4'd1, 8'hFF);

        // Ignored chatter bytes, then typematic repeat and a stray break
        send_byte(8'hFA, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk_row("typematic_held", 4'd4, 8'hFE);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk_row("typematic_released", 4'd4, 8'hFF);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b0);
        chk_row("stray_break", 4'd6, 8'hFF);

        // Bad parity
        send_byte(8'h1C, 1'b1);
        chk_row("bad_parity", 4'd4, 8'hFF);

        // Half frame abandoned by timeout, then RETURN
        send_bits(mkframe(8'h1C, 1'b0), 5);
        repeat (8000) @(negedge clk);
        send_byte(8'h5A, 1'b0);
        chk_row("after_timeout", 4'd6, 8'hDF);
        chk_row("after_timeout_row4", 4'd4, 8'hFF);

        // Overrun clears the matrix
        send_byte(8'h1C, 1'b0);
        chk_row("pre_overrun_a", 4'd4, 8'hFE);
        chk_row("pre_overrun_ret", 4'd6, 8'hDF);
        chk_row("high_row", 4'd12, 8'hFF);
        send_byte(8'hFF, 1'b0);
        for (int r = 0; r < 16; r++) begin
            chk_row("overrun_clear", 4'(r), 8'hFF);
        end

        // Reset mid-frame with A held
        send_byte(8'h1C, 1'b0);
        send_bits(mkframe(8'h5A, 1'b0), 4);
        reset = 1'b1;
        @(negedge clk);
        chk_row("mid_reset_keyin", 4'd4, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_row("reset_cleared_a", 4'd4, 8'hFF);
        send_byte(8'h5A, 1'b0);
        chk_row("after_mid_reset", 4'd6, 8'hDF);

        repeat (20) @(negedge clk);
        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
